// File: rtl/rotating_bank_buffer.sv
// Ring of NUM_BANKS independent memory banks handed between one writer and one
// reader; a bank is filled, committed, read out, then released back to the writer.

module two_port_mem #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [AW-1:0]         addr_a,
  input  logic [BIT_LENGTH-1:0] din_a,
  input  logic                  en_b,
  input  logic [AW-1:0]         addr_b,
  output logic [BIT_LENGTH-1:0] dout_b
);

  logic [BIT_LENGTH-1:0] mem_q [DEPTH];
  logic [BIT_LENGTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_a) mem_q[addr_a] <= din_a;
  end

  // Registered read port; no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (en_b) dout_q <= mem_q[addr_b];
  end

  assign dout_b = dout_q;

endmodule

module rotating_bank_buffer #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  parameter int NUM_BANKS  = 2,
  parameter int AW         = $clog2(DEPTH),
  parameter int BW         = $clog2(NUM_BANKS),
  parameter int CW         = $clog2(NUM_BANKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         wr_addr,
  input  logic [BIT_LENGTH-1:0] wr_din,
  input  logic                  wr_we,
  input  logic                  wr_done,
  output logic                  wr_ready,
  output logic [BW-1:0]         wr_bank,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_en,
  input  logic                  rd_done,
  output logic                  rd_valid,
  output logic [BW-1:0]         rd_bank,
  output logic [BIT_LENGTH-1:0] rd_dout,
  output logic                  rd_dout_vld,
  output logic [CW-1:0]         full_cnt,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [CW-1:0] NB_C = CW'(NUM_BANKS);

  logic [BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] full_cnt_q, full_cnt_d;
  logic          rd_dout_vld_q, rd_dout_vld_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_err_q, rd_err_d;
  logic [BW-1:0] rd_sel_q;

  logic wr_acc, wr_commit, rd_acc, rd_rel;
  logic [BIT_LENGTH-1:0] bank_dout [NUM_BANKS];

  assign wr_ready  = (full_cnt_q != NB_C);
  assign rd_valid  = (full_cnt_q != '0);
  assign wr_bank   = wr_ptr_q;
  assign rd_bank   = rd_ptr_q;
  assign full_cnt  = full_cnt_q;
  assign wr_err    = wr_err_q;
  assign rd_err    = rd_err_q;
  assign rd_dout_vld = rd_dout_vld_q;
  assign rd_dout   = bank_dout[rd_sel_q];

  assign wr_acc    = wr_we   & wr_ready;
  assign wr_commit = wr_done & wr_ready;
  assign rd_acc    = rd_en   & rd_valid;
  assign rd_rel    = rd_done & rd_valid;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    full_cnt_d    = full_cnt_q;
    rd_dout_vld_d = rd_acc;
    wr_err_d      = wr_err_q | ((wr_we | wr_done) & ~wr_ready);
    rd_err_d      = rd_err_q | ((rd_en | rd_done) & ~rd_valid);
    // Pointers wrap naturally because NUM_BANKS is a power of two.
    if (wr_commit) wr_ptr_d = wr_ptr_q + BW'(1);
    if (rd_rel)    rd_ptr_d = rd_ptr_q + BW'(1);
    case ({wr_commit, rd_rel})
      2'b10:   full_cnt_d = full_cnt_q + CW'(1);
      2'b01:   full_cnt_d = full_cnt_q - CW'(1);
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      full_cnt_q    <= '0;
      rd_dout_vld_q <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      full_cnt_q    <= full_cnt_d;
      rd_dout_vld_q <= rd_dout_vld_d;
      wr_err_q      <= wr_err_d;
      rd_err_q      <= rd_err_d;
    end
  end

  // Remember which bank was read so a same-cycle release cannot redirect the data.
  always_ff @(posedge clk) begin
    if (rd_acc) rd_sel_q <= rd_ptr_q;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic we_b, en_b;
    assign we_b = wr_acc & rst_n & (wr_ptr_q == BW'(b));
    assign en_b = rd_acc & rst_n & (rd_ptr_q == BW'(b));
    two_port_mem #(
      .BIT_LENGTH(BIT_LENGTH),
      .DEPTH     (DEPTH),
      .AW        (AW)
    ) u_mem (
      .clk   (clk),
      .we_a  (we_b),
      .addr_a(wr_addr),
      .din_a (wr_din),
      .en_b  (en_b),
      .addr_b(rd_addr),
      .dout_b(bank_dout[b])
    );
  end

endmodule

// File: tb/tb_rotating_bank_buffer.sv
// Directed bench: a 2-bank and a 4-bank buffer driven by the same inputs,
// each checked against hand-computed expectations.

module tb_rotating_bank_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_addr, rd_addr;
  logic [63:0] wr_din;
  logic        wr_we, wr_done, rd_en, rd_done;

  logic        a_wr_ready, a_rd_valid, a_rd_dout_vld, a_wr_err, a_rd_err;
  logic [0:0]  a_wr_bank, a_rd_bank;
  logic [1:0]  a_full_cnt;
  logic [63:0] a_rd_dout;

  logic        b_wr_ready, b_rd_valid, b_rd_dout_vld, b_wr_err, b_rd_err;
  logic [1:0]  b_wr_bank, b_rd_bank;
  logic [2:0]  b_full_cnt;
  logic [63:0] b_rd_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rotating_bank_buffer u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_we(wr_we), .wr_done(wr_done),
    .wr_ready(a_wr_ready), .wr_bank(a_wr_bank),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_done(rd_done),
    .rd_valid(a_rd_valid), .rd_bank(a_rd_bank), .rd_dout(a_rd_dout),
    .rd_dout_vld(a_rd_dout_vld), .full_cnt(a_full_cnt),
    .wr_err(a_wr_err), .rd_err(a_rd_err)
  );

  rotating_bank_buffer #(.NUM_BANKS(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_we(wr_we), .wr_done(wr_done),
    .wr_ready(b_wr_ready), .wr_bank(b_wr_bank),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_done(rd_done),
    .rd_valid(b_rd_valid), .rd_bank(b_rd_bank), .rd_dout(b_rd_dout),
    .rd_dout_vld(b_rd_dout_vld), .full_cnt(b_full_cnt),
    .wr_err(b_wr_err), .rd_err(b_rd_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_we = 0; wr_done = 0; rd_en = 0; rd_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; wr_addr = 0; rd_addr = 0; wr_din = 0;
    idle();
    tick(); tick();
    rst_n = 1;

    // Reset state
    chk("rst_a_wr_ready", a_wr_ready, 1);
    chk("rst_a_rd_valid", a_rd_valid, 0);
    chk("rst_a_full_cnt", a_full_cnt, 0);
    chk("rst_a_banks", {a_wr_bank, a_rd_bank}, 0);
    chk("rst_a_errs", {a_wr_err, a_rd_err, a_rd_dout_vld}, 0);
    chk("rst_b_full_cnt", b_full_cnt, 0);
    chk("rst_b_banks", {b_wr_bank, b_rd_bank}, 0);

    // Fill bank 0 with 0x100+i, then commit
    for (int i = 0; i < 16; i++) begin
      wr_we = 1; wr_addr = 4'(i); wr_din = 64'h100 + 64'(i);
      tick();
    end
    idle(); wr_done = 1;
    tick();
    idle();
    chk("commit_a_rd_valid", a_rd_valid, 1);
    chk("commit_a_rd_bank", a_rd_bank, 0);
    chk("commit_a_full_cnt", a_full_cnt, 1);
    chk("commit_a_wr_bank", a_wr_bank, 1);
    chk("commit_b_wr_bank", b_wr_bank, 1);

    rd_en = 1; rd_addr = 5;
    tick();
    idle();
    chk("read5_a_vld", a_rd_dout_vld, 1);
    chk("read5_a_dout", a_rd_dout, 64'h105);
    chk("read5_b_dout", b_rd_dout, 64'h105);
    tick();
    chk("read_idle_a_vld", a_rd_dout_vld, 0);

    // Ping-pong: fill bank 1 word 5, commit; 2-bank buffer becomes full
    wr_we = 1; wr_addr = 5; wr_din = 64'hBEEF; wr_done = 1;
    tick();
    idle();
    chk("pp_a_full_cnt", a_full_cnt, 2);
    chk("pp_a_wr_ready", a_wr_ready, 0);
    chk("pp_a_wr_bank", a_wr_bank, 0);
    chk("pp_b_wr_ready", b_wr_ready, 1);

    // Read with release in the same cycle comes from the old bank
    rd_en = 1; rd_addr = 5; rd_done = 1;
    tick();
    idle();
    chk("pp_rel_a_dout", a_rd_dout, 64'h105);
    chk("pp_rel_a_rd_bank", a_rd_bank, 1);
    chk("pp_rel_a_full_cnt", a_full_cnt, 1);
    chk("pp_rel_a_wr_ready", a_wr_ready, 1);
    rd_en = 1; rd_addr = 5;
    tick();
    idle();
    chk("pp_bank1_a_dout", a_rd_dout, 64'hBEEF);
    chk("pp_bank1_b_dout", b_rd_dout, 64'hBEEF);

    // Reader protocol error from idle, cleared by reset
    rst_n = 0; tick(); rst_n = 1;
    rd_done = 1; rd_en = 1;
    tick();
    idle();
    chk("rderr_a", a_rd_err, 1);
    chk("rderr_b", b_rd_err, 1);
    chk("rderr_b_rd_bank", b_rd_bank, 0);
    chk("rderr_a_vld", a_rd_dout_vld, 0);
    rst_n = 0; tick(); rst_n = 1;
    chk("rderr_clr_a", a_rd_err, 0);
    chk("rderr_clr_b", b_rd_err, 0);

    // Fill all four banks (write and commit in the same cycle)
    for (int k = 0; k < 4; k++) begin
      wr_we = 1; wr_done = 1; wr_addr = 0; wr_din = 64'h400 + 64'(k);
      tick();
    end
    idle();
    chk("full_b_full_cnt", b_full_cnt, 4);
    chk("full_b_wr_ready", b_wr_ready, 0);
    chk("full_b_wr_bank", b_wr_bank, 0);
    chk("full_a_wr_err", a_wr_err, 1);
    chk("full_a_full_cnt", a_full_cnt, 2);

    wr_we = 1; wr_addr = 0; wr_din = 64'hDEAD;
    tick();
    idle();
    chk("ovf_b_wr_err", b_wr_err, 1);
    chk("ovf_b_wr_bank", b_wr_bank, 0);
    chk("ovf_b_full_cnt", b_full_cnt, 4);
    rd_en = 1; rd_addr = 0;
    tick();
    idle();
    chk("ovf_b_dout", b_rd_dout, 64'h400);
    chk("ovf_a_dout", a_rd_dout, 64'h400);

    // Release two banks, then simultaneous commit and release
    rd_done = 1; tick(); tick();
    idle();
    chk("rel2_b_full_cnt", b_full_cnt, 2);
    chk("rel2_b_rd_bank", b_rd_bank, 2);
    wr_done = 1; rd_done = 1;
    tick();
    idle();
    chk("both_b_full_cnt", b_full_cnt, 2);
    chk("both_b_wr_bank", b_wr_bank, 1);
    chk("both_b_rd_bank", b_rd_bank, 3);
    chk("both_a_full_cnt", a_full_cnt, 1);
    chk("both_a_rd_err", a_rd_err, 1);

    // Wrap of rd_ptr 3 -> 0 with a same-cycle read from bank 3
    rd_en = 1; rd_addr = 0; rd_done = 1;
    tick();
    idle();
    chk("wrap_b_dout", b_rd_dout, 64'h403);
    chk("wrap_b_rd_bank", b_rd_bank, 0);
    chk("wrap_b_full_cnt", b_full_cnt, 1);
    chk("wrap_a_dout", a_rd_dout, 64'h400);
    chk("wrap_a_rd_bank", a_rd_bank, 1);

    // Reset mid-stream blocks the write and read of that cycle
    rst_n = 0; rd_en = 1; rd_addr = 0; wr_we = 1; wr_addr = 0; wr_din = 64'hBAD;
    tick();
    rst_n = 1;
    idle();
    chk("mid_b_full_cnt", b_full_cnt, 0);
    chk("mid_b_wr_bank", b_wr_bank, 0);
    chk("mid_b_rd_valid", b_rd_valid, 0);
    chk("mid_b_vld", b_rd_dout_vld, 0);
    chk("mid_a_vld", a_rd_dout_vld, 0);

    wr_done = 1; tick(); tick();
    idle(); rd_done = 1; tick();
    idle(); rd_en = 1; rd_addr = 0; tick();
    idle();
    chk("mid_b_bank1_kept", b_rd_dout, 64'h401);
    chk("mid_a_bank1_kept", a_rd_dout, 64'h401);
    chk("mid_b_vld_read", b_rd_dout_vld, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rotating_bank_buffer.md
ROTATING_BANK_BUFFER -- requirements
Module: rotating_bank_buffer

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 64, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, words per bank, power of two, >=2.
REQ-003 SHALL have parameter NUM_BANKS, default 2, bank count, power of two, >=2. AW=$clog2(DEPTH), BW=$clog2(NUM_BANKS), CW=$clog2(NUM_BANKS+1).
REQ-004 SHALL have ports:
  clk  in  1  single clock; all logic on rising edge.
  rst_n  in  1  reset; synchronous and active-low.
  wr_addr  in  AW  write word address within the writer's bank.
  wr_din  in  BIT_LENGTH  write data.
  wr_we  in  1  write strobe.
  wr_done  in  1  writer commits its current bank as full.
  wr_ready  out  1  writer owns a free bank.
  wr_bank  out  BW  bank index owned by the writer.
  rd_addr  in  AW  read word address within the reader's bank.
  rd_en  in  1  read request.
  rd_done  in  1  reader releases its current bank.
  rd_valid  out  1  reader owns a full bank.
  rd_bank  out  BW  bank index owned by the reader.
  rd_dout  out  BIT_LENGTH  read data.
  rd_dout_vld  out  1  rd_dout carries valid data this cycle.
  full_cnt  out  CW  number of committed, unreleased banks.
  wr_err  out  1  sticky writer protocol error.
  rd_err  out  1  sticky reader protocol error.

Function
REQ-005 SHALL hold NUM_BANKS independent DEPTH x BIT_LENGTH banks, each a two_port_mem instance, write port A, read port B.
REQ-006 SHALL track wr_ptr (BW), rd_ptr (BW), full_cnt (CW); banks form a ring, wr_ptr and rd_ptr wrap from NUM_BANKS-1 to 0.
REQ-007 SHALL drive wr_bank=wr_ptr, rd_bank=rd_ptr, wr_ready=(full_cnt<NUM_BANKS), rd_valid=(full_cnt>0), all combinational from registers.
REQ-008 SHALL write wr_din to bank wr_ptr at wr_addr when wr_we && wr_ready; no bank written otherwise.
REQ-009 SHALL, on wr_done && wr_ready, advance wr_ptr by one at the clock edge; a write in that same cycle lands in the old bank.
REQ-010 SHALL, on rd_done && rd_valid, advance rd_ptr by one at the clock edge.
REQ-011 SHALL update full_cnt: +1 on accepted wr_done only, -1 on accepted rd_done only, unchanged when both accepted in one cycle.
REQ-012 SHALL, on rd_en && rd_valid at cycle t, present bank rd_ptr(t) word rd_addr(t) on rd_dout with rd_dout_vld=1 at cycle t+1 (latency 1); a rd_done in cycle t does not affect that read.
REQ-013 SHALL hold rd_dout_vld=0 in any cycle following one without accepted read; rd_dout value is unspecified when rd_dout_vld=0.
REQ-014 SHALL give commit-to-visibility latency of one cycle: accepted wr_done at t -> rd_valid=1 at t+1 when full_cnt was 0.
REQ-015 SHALL allow a write and read to the same bank in the same cycle only when NUM_BANKS banks are full is impossible by construction (writer never owns rd_ptr bank while rd_valid unless full_cnt=0); no bypass of same-cycle write data to reads.
REQ-016 SHALL set wr_err=1 (sticky) on wr_we or wr_done while wr_ready=0; the request is ignored.
REQ-017 SHALL set rd_err=1 (sticky) on rd_en or rd_done while rd_valid=0; the request is ignored and rd_dout_vld=0 next cycle.
REQ-018 SHALL, with NUM_BANKS=2, behave as a classic ping-pong pair: writer and reader alternate banks 0/1.

Reset
REQ-019 SHALL, while rst_n=0 at a clock edge, set wr_ptr=0, rd_ptr=0, full_cnt=0, rd_dout_vld=0, wr_err=0, rd_err=0; hence wr_ready=1, rd_valid=0, wr_bank=0, rd_bank=0.
REQ-020 SHALL not clear bank contents on reset; reset mid-operation discards all commitments and blocks writes/reads in that cycle.

Verification
REQ-021 Default params: write words 0..15 = 0x100+i to bank 0, wr_done -> next cycle rd_valid=1, rd_bank=0, full_cnt=1, wr_bank=1; rd_en addr 5 -> rd_dout=0x105, rd_dout_vld=1 one cycle later.
REQ-022 NUM_BANKS=4: four wr_done with no rd_done -> full_cnt=4, wr_ready=0; fifth wr_we -> wr_err=1, no bank modified, wr_bank stays 0.
REQ-023 full_cnt=2, NUM_BANKS=4: wr_done and rd_done same cycle -> full_cnt stays 2, wr_ptr and rd_ptr each +1.
REQ-024 rd_ptr=3 of 4 banks: rd_done -> rd_bank=0 (wrap); rd_en with rd_done same cycle returns data from bank 3.
REQ-025 rd_done at reset-idle (full_cnt=0) -> rd_err=1, rd_ptr stays 0; then rst_n=0 one cycle -> rd_err=0.
REQ-026 Mid-stream (full_cnt=1, wr_ptr=1) assert rst_n=0 -> next cycle full_cnt=0, wr_bank=0, rd_valid=0, rd_dout_vld=0.
